bsg_upscale_pixel_sched: RTL and testbench

BSG_UPSCALE_PIXEL_SCHED -- requirements
Module: bsg_upscale_pixel_sched

---
 rtl/bsg_upscale_pixel_sched.sv | 136 +++++++++++++
 tb/tb_bsg_upscale_pixel_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_upscale_pixel_sched.sv
// Pixel scheduler: gathers R/G/B interpolator outputs into a triplet FIFO and
// serializes each pixel as three bytes to a valid/yumi link, sequencing one frame per start.
module bsg_upscale_pixel_sched #(
    parameter int els_p = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [11:0] out_w_i,
    input  logic [11:0] out_h_i,
    input  logic        r_v_i,
    input  logic        g_v_i,
    input  logic        b_v_i,
    input  logic [7:0]  r_data_i,
    input  logic [7:0]  g_data_i,
    input  logic [7:0]  b_data_i,
    output logic        stall_o,
    output logic        v_o,
    output logic [7:0]  data_o,
    input  logic        yumi_i,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o
);

    localparam int aw_lp = $clog2(els_p);
    localparam logic [aw_lp:0] els_lp    = (aw_lp+1)'(els_p);
    localparam logic [aw_lp:0] almost_lp = (aw_lp+1)'(els_p - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e         state, state_n;
    logic [11:0]    w_r, h_r;
    logic [23:0]    cnt_r;
    logic [23:0]    target;
    logic           err_r;

    logic [23:0]    mem [els_p];
    logic [aw_lp:0] wptr_r, rptr_r;
    logic [aw_lp:0] count;
    logic           empty, full;
    logic [1:0]     sel_r;
    logic [23:0]    head;

    logic           any_v, all_v;
    logic           start_ok;
    logic           push, pop, adv;
    logic           err_set;

    assign target   = 24'(w_r) * 24'(h_r);
    assign count    = wptr_r - rptr_r;
    assign empty    = (count == '0);
    assign full     = (count == els_lp);
    assign head     = mem[rptr_r[aw_lp-1:0]];

    assign any_v    = r_v_i | g_v_i | b_v_i;
    assign all_v    = r_v_i & g_v_i & b_v_i;
    assign start_ok = (state == IDLE) && start_i && (out_w_i != '0) && (out_h_i != '0);

    // Push looks only at registered occupancy, so a same-cycle pop never frees a slot for it.
    assign push     = (state == RUN) && all_v && !full;
    assign adv      = yumi_i && !empty;
    assign pop      = adv && (sel_r == 2'd2);
    assign err_set  = (state == RUN) ? ((any_v && !all_v) || (all_v && full)) : any_v;

    assign v_o      = !empty;
    assign err_o    = err_r;

    always_comb begin
        data_o = '0;
        if (!empty) begin
            case (sel_r)
                2'd0:    data_o = head[23:16];
                2'd1:    data_o = head[15:8];
                default: data_o = head[7:0];
            endcase
        end
    end

    always_comb begin
        state_n      = state;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        stall_o      = 1'b1;
        case (state)
            IDLE: begin
                if (start_ok) state_n = RUN;
            end
            RUN: begin
                busy_o  = 1'b1;
                stall_o = (count >= almost_lp);
                if (push && (cnt_r + 24'd1 == target)) state_n = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (empty && (sel_r == 2'd0)) state_n = DONE;
            end
            DONE: begin
                frame_done_o = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            w_r    <= '0;
            h_r    <= '0;
            cnt_r  <= '0;
            err_r  <= 1'b0;
            wptr_r <= '0;
            rptr_r <= '0;
            sel_r  <= '0;
        end else begin
            state <= state_n;
            if (start_ok) begin
                w_r   <= out_w_i;
                h_r   <= out_h_i;
                cnt_r <= '0;
            end else if (push) begin
                cnt_r <= cnt_r + 24'd1;
            end
            if (err_set) err_r <= 1'b1;
            if (push) wptr_r <= wptr_r + 1'b1;
            if (pop)  rptr_r <= rptr_r + 1'b1;
            if (adv)  sel_r  <= (sel_r == 2'd2) ? 2'd0 : sel_r + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_r[aw_lp-1:0]] <= {r_data_i, g_data_i, b_data_i};
    end

endmodule

// File: tb/tb_bsg_upscale_pixel_sched.sv
// Self-checking bench for bsg_upscale_pixel_sched: directed frame scenarios plus a
// randomized run checked cycle by cycle against a queue-based frame/byte-stream model.
module tb_bsg_upscale_pixel_sched;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0, start_i = 1'b0, yumi_i = 1'b0;
    logic [11:0] out_w_i = '0, out_h_i = '0;
    logic        r_v_i = 1'b0, g_v_i = 1'b0, b_v_i = 1'b0;
    logic [7:0]  r_data_i = '0, g_data_i = '0, b_data_i = '0;
    logic        stall_o, v_o, busy_o, frame_done_o, err_o;
    logic [7:0]  data_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame phase, queue of whole pixels, byte position within head pixel.
    int          m_mode = 0;  // 0 idle, 1 collecting, 2 draining, 3 done pulse
    logic [23:0] m_q[$];
    int          m_sel = 0;
    int          m_acc = 0;
    int          m_target = 0;
    bit          m_err = 0;

    always #5 clk = ~clk;

    bsg_upscale_pixel_sched #(.els_p(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .out_w_i(out_w_i), .out_h_i(out_h_i),
        .r_v_i(r_v_i), .g_v_i(g_v_i), .b_v_i(b_v_i),
        .r_data_i(r_data_i), .g_data_i(g_data_i), .b_data_i(b_data_i),
        .stall_o(stall_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
    );

    function automatic logic [7:0] byte_of(input logic [23:0] p, input int s);
        return p[23 - 8*s -: 8];
    endfunction

    task automatic step();
        int  qn;
        bit  anyv, allv;
        @(posedge clk);
        qn   = m_q.size();
        anyv = r_v_i | g_v_i | b_v_i;
        allv = r_v_i & g_v_i & b_v_i;
        if (reset_i) begin
            m_mode = 0; m_q.delete(); m_sel = 0; m_acc = 0; m_err = 0;
        end else begin
            if (yumi_i && qn > 0) begin
                if (m_sel == 2) begin
                    void'(m_q.pop_front());
                    m_sel = 0;
                end else m_sel++;
            end
            case (m_mode)
                0: begin
                    if (anyv) m_err = 1;
                    if (start_i && out_w_i != 0 && out_h_i != 0) begin
                        m_mode = 1; m_acc = 0; m_target = int'(out_w_i) * int'(out_h_i);
                    end
                end
                1: begin
                    if (allv) begin
                        if (qn < DEPTH) begin
                            m_q.push_back({r_data_i, g_data_i, b_data_i});
                            m_acc++;
                            if (m_acc == m_target) m_mode = 2;
                        end else m_err = 1;
                    end else if (anyv) m_err = 1;
                end
                2: begin
                    if (anyv) m_err = 1;
                    if (qn == 0) m_mode = 3;
                end
                default: begin
                    if (anyv) m_err = 1;
                    m_mode = 0;
                end
            endcase
        end
        #1;
    endtask

    task automatic set_px(input logic [23:0] p);
        {r_data_i, g_data_i, b_data_i} = p;
        {r_v_i, g_v_i, b_v_i} = 3'b111;
    endtask

    task automatic clr_v();
        {r_v_i, g_v_i, b_v_i} = 3'b000;
    endtask

    task automatic do_reset();
        clr_v(); start_i = 0; yumi_i = 0;
        reset_i = 1; step(); reset_i = 0;
    endtask

    task automatic start_frame(input int w, input int h);
        out_w_i = 12'(w); out_h_i = 12'(h); start_i = 1;
        step();
        start_i = 0;
    endtask

    // Pop bytes legally until the FIFO is empty, bounded; counts done pulses seen.
    task automatic drain(inout logic [7:0] got[$], inout int dones);
        for (int i = 0; i < 80; i++) begin
            yumi_i = v_o;
            if (v_o) got.push_back(data_o);
            step();
            if (frame_done_o) dones++;
        end
        yumi_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v got %b want 0", v_o); end
        n_tests++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_o); end
        n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", stall_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_tests++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
    endtask

    task automatic test_basic_frame();
        logic [7:0]  got[$];
        logic [7:0]  exp_b[6];
        logic [23:0] px[2];
        int          dones = 0;
        px[0] = 24'h112233; px[1] = 24'h445566;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        start_frame(2, 1);
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b want 1", busy_o); end
        yumi_i = 1;
        for (int i = 0; i < 24; i++) begin
            if (i < 2) set_px(px[i]); else clr_v();
            if (v_o) got.push_back(data_o);
            step();
            if (frame_done_o) dones++;
        end
        yumi_i = 0;
        n_tests++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL basic_count got %0d bytes want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_b[i]); end
            end
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", dones); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", err_o); end
    endtask

    task automatic test_fifo_full();
        logic [23:0] px[5];
        logic [7:0]  got[$];
        int          dones = 0;
        for (int i = 0; i < 5; i++) px[i] = 24'($urandom);
        do_reset();
        start_frame(4, 2);
        for (int k = 0; k < 3; k++) begin
            set_px(px[k]); step();
            n_tests++;
            if (stall_o !== (k == 2)) begin n_fail++; $display("FAIL full_stall_after%0d got %b want %b", k+1, stall_o, k == 2); end
        end
        set_px(px[3]); step();
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL full_4th_err got %b want 0", err_o); end
        set_px(px[4]); step();
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL full_5th_err got %b want 1", err_o); end
        clr_v();
        drain(got, dones);
        n_tests++;
        if (got.size() != 12) begin
            n_fail++; $display("FAIL full_count got %0d bytes want 12", got.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (got[i] !== byte_of(px[i/3], i%3)) begin
                    n_fail++; $display("FAIL full_byte%0d got %h want %h", i, got[i], byte_of(px[i/3], i%3));
                end
            end
        end
    endtask

    task automatic test_partial_valid();
        logic [23:0] p;
        logic [7:0]  got[$];
        int          dones = 0;
        p = 24'($urandom);
        do_reset();
        start_frame(1, 1);
        {r_data_i, g_data_i, b_data_i} = 24'($urandom);
        {r_v_i, g_v_i, b_v_i} = 3'b110;
        step(); clr_v();
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL partial_err got %b want 1", err_o); end
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL partial_v got %b want 0", v_o); end
        step();
        n_tests++; if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL partial_still_run got stall=%b busy=%b want stall=0 busy=1", stall_o, busy_o);
        end
        set_px(p); step(); clr_v();
        drain(got, dones);
        n_tests++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL partial_count got %0d bytes want 3", got.size());
        end else begin
            n_tests++;
            if ({got[0], got[1], got[2]} !== p) begin n_fail++; $display("FAIL partial_pixel got %h%h%h want %h", got[0], got[1], got[2], p); end
        end
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL partial_done got %0d want 1", dones); end
    endtask

    task automatic test_start_ignore();
        logic [7:0] got[$];
        int         dones = 0;
        do_reset();
        start_frame(0, 5);
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_w_busy got %b want 0", busy_o); end
        start_frame(7, 0);
        for (int i = 0; i < 4; i++) begin step(); if (frame_done_o) dones++; end
        n_tests++; if (busy_o !== 1'b0 || dones != 0) begin
            n_fail++; $display("FAIL zero_h got busy=%b dones=%0d want 0 0", busy_o, dones);
        end
        start_frame(2, 1);
        set_px(24'h0a0b0c); out_w_i = 1; out_h_i = 1; start_i = 1;
        step(); start_i = 0;
        n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL restart_run_stall got %b want 0", stall_o); end
        set_px(24'h0d0e0f); step(); clr_v();
        n_tests++; if (stall_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL restart_drain got stall=%b busy=%b want 1 1", stall_o, busy_o);
        end
        drain(got, dones);
        n_tests++; if (got.size() != 6 || dones != 1) begin
            n_fail++; $display("FAIL restart_frame got bytes=%0d dones=%0d want 6 1", got.size(), dones);
        end
    endtask

    task automatic test_reset_drain();
        do_reset();
        start_frame(2, 1);
        set_px(24'($urandom)); step();
        set_px(24'($urandom)); step();
        clr_v(); r_v_i = 1; step(); clr_v();
        n_tests++; if (busy_o !== 1'b1 || v_o !== 1'b1 || err_o !== 1'b1) begin
            n_fail++; $display("FAIL drain_pre got busy=%b v=%b err=%b want 1 1 1", busy_o, v_o, err_o);
        end
        reset_i = 1; step(); reset_i = 0;
        n_tests++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL rst_drain_v got %b want 0", v_o); end
        n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_drain_stall got %b want 1", stall_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_drain_err got %b want 0", err_o); end
        n_tests++; if (busy_o !== 1'b0 || data_o !== 8'h00) begin
            n_fail++; $display("FAIL rst_drain_idle got busy=%b data=%h want 0 00", busy_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] px[3];
        logic [7:0]  got[$];
        int          dones = 0;
        for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
        do_reset();
        start_frame(4, 1);
        set_px(px[0]); step();
        set_px(px[1]); step();
        clr_v(); yumi_i = 1;
        for (int i = 0; i < 2; i++) begin got.push_back(data_o); step(); end
        set_px(px[2]); got.push_back(data_o); step();
        clr_v(); yumi_i = 0;
        n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_occupancy_stall got %b want 0", stall_o); end
        n_tests++; if (v_o !== 1'b1 || data_o !== px[1][23:16]) begin
            n_fail++; $display("FAIL b2b_head got v=%b data=%h want 1 %h", v_o, data_o, px[1][23:16]);
        end
        drain(got, dones);
        n_tests++;
        if (got.size() != 9) begin
            n_fail++; $display("FAIL b2b_count got %0d bytes want 9", got.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_tests++;
                if (got[i] !== byte_of(px[i/3], i%3)) begin
                    n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, got[i], byte_of(px[i/3], i%3));
                end
            end
        end
    endtask

    task automatic test_random();
        int          r, qn;
        logic [7:0]  exp_d;
        bit          exp_v, exp_stall, exp_busy, exp_done;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset_i = ($urandom_range(0, 99) < 2);
            start_i = ($urandom_range(0, 9) == 0);
            out_w_i = 12'($urandom_range(0, 3));
            out_h_i = 12'($urandom_range(0, 3));
            {r_data_i, g_data_i, b_data_i} = 24'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6)      {r_v_i, g_v_i, b_v_i} = 3'b111;
            else if (r < 7) {r_v_i, g_v_i, b_v_i} = 3'($urandom_range(1, 6));
            else            {r_v_i, g_v_i, b_v_i} = 3'b000;
            yumi_i = v_o && ($urandom_range(0, 2) != 0);
            step();
            qn        = m_q.size();
            exp_v     = (qn > 0);
            exp_d     = exp_v ? byte_of(m_q[0], m_sel) : 8'h00;
            exp_stall = (m_mode != 1) || (DEPTH - qn <= 1);
            exp_busy  = (m_mode == 1) || (m_mode == 2);
            exp_done  = (m_mode == 3);
            n_tests++; if (v_o !== exp_v) begin n_fail++; $display("FAIL rnd_v cyc%0d got %b want %b", cyc, v_o, exp_v); end
            n_tests++; if (data_o !== exp_d) begin n_fail++; $display("FAIL rnd_data cyc%0d got %h want %h", cyc, data_o, exp_d); end
            n_tests++; if (stall_o !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %b want %b", cyc, stall_o, exp_stall); end
            n_tests++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc%0d got %b want %b", cyc, busy_o, exp_busy); end
            n_tests++; if (frame_done_o !== exp_done) begin n_fail++; $display("FAIL rnd_done cyc%0d got %b want %b", cyc, frame_done_o, exp_done); end
            n_tests++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err cyc%0d got %b want %b", cyc, err_o, m_err); end
        end
        reset_i = 0; clr_v(); yumi_i = 0; start_i = 0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_fifo_full();
        test_partial_valid();
        test_start_ignore();
        test_reset_drain();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
